// File: rtl/cam_rgb444_capture_if.sv
// Camera pin bundle plus frame-buffer write port. The capture block uses
// the slave view; the camera/frame-buffer side (or a bench) uses the master view.
interface cam_rgb444_capture_if #(
  parameter int AW = 15,
  parameter int DW = 12
);
  logic          CAM_PCLK;
  logic          CAM_VSYNC;
  logic          CAM_HREF;
  logic [7:0]    CAM_px_data;
  logic [AW-1:0] DP_RAM_addr_in;
  logic [DW-1:0] DP_RAM_data_in;
  logic          DP_RAM_regW;
  logic          frame_done;
  logic          overflow_err;

  modport master (
    output CAM_PCLK, CAM_VSYNC, CAM_HREF, CAM_px_data,
    input  DP_RAM_addr_in, DP_RAM_data_in, DP_RAM_regW, frame_done, overflow_err
  );

  modport slave (
    input  CAM_PCLK, CAM_VSYNC, CAM_HREF, CAM_px_data,
    output DP_RAM_addr_in, DP_RAM_data_in, DP_RAM_regW, frame_done, overflow_err
  );
endinterface

// File: rtl/cam_rgb444_capture.sv
// OV7670-style RGB444 capture into a row-major frame buffer, sampled in clk.
// States: WAIT_VS (await blanking) | WAIT_START (await VSYNC fall) | CAPTURE (store pixels)
module cam_rgb444_capture #(
  parameter int IMG_W = 160,
  parameter int IMG_H = 120,
  parameter int AW    = 15,
  parameter int DW    = 12
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  cam_rgb444_capture_if.slave  bus
);
  localparam int CW = $clog2(IMG_W + 1);
  localparam int RW = $clog2(IMG_H + 1);

  typedef enum logic [1:0] {WAIT_VS, WAIT_START, CAPTURE} state_t;

  state_t        r_state;
  state_t        w_state_nx;

  logic          r_pclk_s1, r_pclk_s2, r_pclk_s3;
  logic          r_vs_s1, r_vs_s2, r_vs_prev;
  logic          r_href_s1, r_href_s2, r_href_prev;
  logic [7:0]    r_px_s1, r_px_s2;

  logic          w_pclk_rise, w_vs_rise, w_vs_fall, w_href_fall;
  logic          w_clear, w_take_byte, w_line_end, w_frame_end, w_in_frame;

  logic [AW-1:0] r_addr, r_base;
  logic [DW-1:0] r_data;
  logic          r_regw, r_fd_pend, r_frame_done, r_ovf, r_phase;
  logic [3:0]    r_red;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;

  // Edges of VSYNC/HREF are judged between successive PCLK rises, as the camera launches them.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pclk_s1   <= 1'b0;
      r_pclk_s2   <= 1'b0;
      r_pclk_s3   <= 1'b0;
      r_vs_s1     <= 1'b0;
      r_vs_s2     <= 1'b0;
      r_vs_prev   <= 1'b0;
      r_href_s1   <= 1'b0;
      r_href_s2   <= 1'b0;
      r_href_prev <= 1'b0;
      r_px_s1     <= '0;
      r_px_s2     <= '0;
    end else begin
      r_pclk_s1 <= bus.CAM_PCLK;
      r_pclk_s2 <= r_pclk_s1;
      r_pclk_s3 <= r_pclk_s2;
      r_vs_s1   <= bus.CAM_VSYNC;
      r_vs_s2   <= r_vs_s1;
      r_href_s1 <= bus.CAM_HREF;
      r_href_s2 <= r_href_s1;
      r_px_s1   <= bus.CAM_px_data;
      r_px_s2   <= r_px_s1;
      if (w_pclk_rise) begin
        r_vs_prev   <= r_vs_s2;
        r_href_prev <= r_href_s2;
      end
    end
  end

  assign w_pclk_rise = r_pclk_s2 & ~r_pclk_s3;
  assign w_vs_rise   = w_pclk_rise & r_vs_s2 & ~r_vs_prev;
  assign w_vs_fall   = w_pclk_rise & ~r_vs_s2 & r_vs_prev;
  assign w_href_fall = w_pclk_rise & ~r_href_s2 & r_href_prev;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= WAIT_VS;
    else       r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      WAIT_VS:    if (w_pclk_rise && r_vs_s2) w_state_nx = WAIT_START;
      WAIT_START: if (w_vs_fall)              w_state_nx = CAPTURE;
      CAPTURE:    if (w_vs_rise)              w_state_nx = WAIT_START;
      default:                                w_state_nx = WAIT_VS;
    endcase
  end

  always_comb begin
    w_clear     = 1'b0;
    w_take_byte = 1'b0;
    w_line_end  = 1'b0;
    w_frame_end = 1'b0;
    case (r_state)
      WAIT_START: w_clear = w_vs_fall;
      CAPTURE: begin
        w_take_byte = w_pclk_rise & r_href_s2;
        w_line_end  = w_href_fall;
        w_frame_end = w_vs_rise;
      end
      default: ;
    endcase
  end

  assign w_in_frame = (r_col < CW'(IMG_W)) && (r_row < RW'(IMG_H));

  // frame_done trails by one extra flop so a coincident final write is strobed first.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_addr       <= '0;
      r_data       <= '0;
      r_regw       <= 1'b0;
      r_fd_pend    <= 1'b0;
      r_frame_done <= 1'b0;
      r_ovf        <= 1'b0;
      r_phase      <= 1'b0;
      r_red        <= '0;
      r_col        <= '0;
      r_row        <= '0;
      r_base       <= '0;
    end else begin
      r_regw       <= 1'b0;
      r_fd_pend    <= w_frame_end;
      r_frame_done <= r_fd_pend;
      if (w_clear) begin
        r_col   <= '0;
        r_row   <= '0;
        r_base  <= '0;
        r_phase <= 1'b0;
        r_ovf   <= 1'b0;
      end else if (w_take_byte) begin
        if (!r_phase) begin
          r_red   <= r_px_s2[3:0];
          r_phase <= 1'b1;
        end else begin
          r_phase <= 1'b0;
          if (w_in_frame) begin
            r_addr <= r_base + AW'(r_col);
            r_data <= DW'({r_red, r_px_s2});
            r_regw <= 1'b1;
          end else begin
            r_ovf <= 1'b1;
          end
          if (r_col < CW'(IMG_W)) r_col <= r_col + CW'(1);
        end
      end else if (w_line_end) begin
        r_phase <= 1'b0;
        if (r_col != '0) begin
          r_col <= '0;
          if (r_row < RW'(IMG_H)) begin
            r_row  <= r_row + RW'(1);
            r_base <= r_base + AW'(IMG_W);
          end
        end
      end
    end
  end

  assign bus.DP_RAM_addr_in = r_addr;
  assign bus.DP_RAM_data_in = r_data;
  assign bus.DP_RAM_regW    = r_regw;
  assign bus.frame_done     = r_frame_done;
  assign bus.overflow_err   = r_ovf;
endmodule

// File: tb/tb_cam_rgb444_capture.sv
// Randomized bench for cam_rgb444_capture; a reduced 40x30 image keeps full frames short,
// with expected writes computed as row*W+col per received pixel.
module tb_cam_rgb444_capture;
  localparam int W = 40;
  localparam int H = 30;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cam_rgb444_capture_if #(.AW(15), .DW(12)) bus ();

  cam_rgb444_capture #(.IMG_W(W), .IMG_H(H), .AW(15), .DW(12)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [26:0] obs_q[$];
  logic [26:0] exp_q[$];
  logic [7:0]  line_q[$];
  int          fd_cnt = 0;
  time         t_wr = 0;
  time         t_fd = 0;
  int          m_row = 0;
  bit          m_ovf = 1'b0;

  always @(negedge clk) begin
    if (bus.DP_RAM_regW === 1'b1) begin
      obs_q.push_back({bus.DP_RAM_addr_in, bus.DP_RAM_data_in});
      t_wr = $time;
    end
    if (bus.frame_done === 1'b1) begin
      fd_cnt++;
      t_fd = $time;
    end
  end

  // One camera byte period: PCLK low two clk, high two clk; data launched while low.
  task automatic pclk_cycle(input logic [7:0] b, input logic href, input logic vs);
    @(negedge clk);
    bus.CAM_px_data = b;
    bus.CAM_HREF    = href;
    bus.CAM_VSYNC   = vs;
    bus.CAM_PCLK    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.CAM_PCLK = 1'b1;
    @(negedge clk);
  endtask

  task automatic make_line(input int n);
    line_q.delete();
    for (int i = 0; i < n; i++) line_q.push_back(8'($urandom_range(0, 255)));
  endtask

  // Reference: pixel i of the current line lands at m_row*W+i while inside the image.
  task automatic send_line();
    int np;
    np = line_q.size() / 2;
    for (int i = 0; i < np; i++) begin
      if (i < W && m_row < H) exp_q.push_back({15'(m_row * W + i), line_q[2*i][3:0], line_q[2*i+1]});
      else m_ovf = 1'b1;
    end
    if (np > 0 && m_row < H) m_row++;
    foreach (line_q[i]) pclk_cycle(line_q[i], 1'b1, 1'b0);
    pclk_cycle(8'h00, 1'b0, 1'b0);
    pclk_cycle(8'h00, 1'b0, 1'b0);
  endtask

  task automatic frame_start(input logic href_at_fall);
    pclk_cycle(8'h00, 1'b0, 1'b1);
    pclk_cycle(8'h00, 1'b0, 1'b1);
    pclk_cycle(8'h00, href_at_fall, 1'b0);
    m_row = 0;
    m_ovf = 1'b0;
  endtask

  task automatic frame_end();
    pclk_cycle(8'h00, 1'b0, 1'b1);
    pclk_cycle(8'h00, 1'b0, 1'b1);
  endtask

  task automatic settle();
    repeat (10) @(negedge clk);
  endtask

  task automatic clear_obs();
    obs_q.delete();
    exp_q.delete();
    fd_cnt = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) pclk_cycle(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b1);
    n_vec++; if (bus.DP_RAM_addr_in !== 15'd0) begin n_err++; $display("FAIL rst_addr: got %h exp 0", bus.DP_RAM_addr_in); end
    n_vec++; if (bus.DP_RAM_data_in !== 12'd0) begin n_err++; $display("FAIL rst_data: got %h exp 0", bus.DP_RAM_data_in); end
    n_vec++; if (bus.DP_RAM_regW !== 1'b0) begin n_err++; $display("FAIL rst_regw: got %b exp 0", bus.DP_RAM_regW); end
    n_vec++; if (bus.frame_done !== 1'b0) begin n_err++; $display("FAIL rst_fd: got %b exp 0", bus.frame_done); end
    n_vec++; if (bus.overflow_err !== 1'b0) begin n_err++; $display("FAIL rst_ovf: got %b exp 0", bus.overflow_err); end
    clear_obs();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) pclk_cycle(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b1);
    settle();
    n_vec++; if (obs_q.size() != 0) begin n_err++; $display("FAIL idle_writes: got %0d exp 0", obs_q.size()); end
    n_vec++; if (fd_cnt != 0) begin n_err++; $display("FAIL idle_fd: got %0d exp 0", fd_cnt); end
  endtask

  task automatic test_single_line();
    clear_obs();
    frame_start(1'b0);
    line_q.delete();
    for (int i = 0; i < W; i++) begin line_q.push_back(8'h0F); line_q.push_back(8'hF0); end
    send_line();
    settle();
    n_vec++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL single_count: got %0d exp %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_vec++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL single_wr[%0d]: got %h exp %h", i, obs_q[i], exp_q[i]); end
    end
    n_vec++; if (bus.DP_RAM_addr_in !== 15'(W - 1)) begin n_err++; $display("FAIL single_addr_hold: got %0d exp %0d", bus.DP_RAM_addr_in, W - 1); end
    n_vec++; if (bus.overflow_err !== 1'b0) begin n_err++; $display("FAIL single_ovf: got %b exp 0", bus.overflow_err); end
    frame_end();
    settle();
  endtask

  task automatic test_full_frame();
    clear_obs();
    frame_start(1'b0);
    for (int i = 0; i < 16; i++) pclk_cycle(8'h00, 1'b0, 1'b0);
    for (int l = 0; l < H; l++) begin make_line(2 * W); send_line(); end
    frame_end();
    settle();
    n_vec++; if (obs_q.size() != W * H) begin n_err++; $display("FAIL full_count: got %0d exp %0d", obs_q.size(), W * H); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_vec++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL full_wr[%0d]: got %h exp %h", i, obs_q[i], exp_q[i]); end
    end
    n_vec++; if (bus.DP_RAM_addr_in !== 15'(W * H - 1)) begin n_err++; $display("FAIL full_last_addr: got %0d exp %0d", bus.DP_RAM_addr_in, W * H - 1); end
    n_vec++; if (fd_cnt != 1) begin n_err++; $display("FAIL full_fd: got %0d exp 1", fd_cnt); end
    n_vec++; if (t_fd <= t_wr) begin n_err++; $display("FAIL full_fd_order: got fd@%0t wr@%0t", t_fd, t_wr); end
    n_vec++; if (bus.overflow_err !== 1'b0) begin n_err++; $display("FAIL full_ovf: got %b exp 0", bus.overflow_err); end
  endtask

  task automatic test_overflow();
    clear_obs();
    frame_start(1'b0);
    make_line(2 * W + 2);
    send_line();
    settle();
    n_vec++; if (obs_q.size() != W) begin n_err++; $display("FAIL ovf_line_count: got %0d exp %0d", obs_q.size(), W); end
    n_vec++; if (bus.overflow_err !== m_ovf) begin n_err++; $display("FAIL ovf_set: got %b exp %b", bus.overflow_err, m_ovf); end
    for (int l = 1; l < H; l++) begin make_line(2 * $urandom_range(1, 3)); send_line(); end
    make_line(2 * W);
    send_line();
    settle();
    n_vec++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL ovf_count: got %0d exp %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_vec++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL ovf_wr[%0d]: got %h exp %h", i, obs_q[i], exp_q[i]); end
    end
    frame_end();
    settle();
    n_vec++; if (bus.overflow_err !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b exp 1", bus.overflow_err); end
    frame_start(1'b0);
    settle();
    n_vec++; if (bus.overflow_err !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b exp 0", bus.overflow_err); end
    frame_end();
    settle();
  endtask

  task automatic test_odd_line();
    clear_obs();
    frame_start(1'b1);
    line_q = '{8'h0A, 8'hBC, 8'h0D, 8'hEF, 8'h01};
    send_line();
    make_line(4);
    exp_q.push_back({15'(W), line_q[0][3:0], line_q[1]});
    exp_q.push_back({15'(W + 1), line_q[2][3:0], line_q[3]});
    pclk_cycle(line_q[0], 1'b1, 1'b0);
    pclk_cycle(line_q[1], 1'b1, 1'b0);
    pclk_cycle(line_q[2], 1'b1, 1'b0);
    pclk_cycle(line_q[3], 1'b1, 1'b1);
    pclk_cycle(8'h00, 1'b0, 1'b1);
    settle();
    n_vec++; if (obs_q.size() != 4) begin n_err++; $display("FAIL odd_count: got %0d exp 4", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_vec++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL odd_wr[%0d]: got %h exp %h", i, obs_q[i], exp_q[i]); end
    end
    n_vec++; if (fd_cnt != 1) begin n_err++; $display("FAIL odd_fd: got %0d exp 1", fd_cnt); end
    n_vec++; if (t_fd <= t_wr) begin n_err++; $display("FAIL odd_fd_order: got fd@%0t wr@%0t", t_fd, t_wr); end
  endtask

  task automatic test_latency();
    int k;
    logic [26:0] want;
    clear_obs();
    frame_start(1'b0);
    pclk_cycle(8'h05, 1'b1, 1'b0);
    @(negedge clk);
    bus.CAM_px_data = 8'hA7;
    bus.CAM_HREF    = 1'b1;
    bus.CAM_PCLK    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.CAM_PCLK = 1'b1;
    k = 0;
    while (k < 10) begin
      @(negedge clk);
      k++;
      if (bus.DP_RAM_regW === 1'b1) break;
    end
    n_vec++; if (k != 3) begin n_err++; $display("FAIL latency: got %0d clk exp 3", k); end
    pclk_cycle(8'h00, 1'b0, 1'b0);
    pclk_cycle(8'h00, 1'b0, 1'b0);
    frame_end();
    settle();
    want = {15'd0, 12'h5A7};
    n_vec++; if (obs_q.size() != 1) begin n_err++; $display("FAIL lat_count: got %0d exp 1", obs_q.size()); end
    else begin
      n_vec++; if (obs_q[0] !== want) begin n_err++; $display("FAIL lat_wr: got %h exp %h", obs_q[0], want); end
    end
  endtask

  task automatic test_reset_mid();
    int n0;
    clear_obs();
    frame_start(1'b0);
    for (int l = 0; l < 19; l++) begin make_line(2 * $urandom_range(1, 5)); send_line(); end
    make_line(2 * W);
    for (int p = 0; p < 3; p++) exp_q.push_back({15'(m_row * W + p), line_q[2*p][3:0], line_q[2*p+1]});
    for (int i = 0; i < 6; i++) pclk_cycle(line_q[i], 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++; if (bus.DP_RAM_regW !== 1'b0) begin n_err++; $display("FAIL mid_rst_regw: got %b exp 0", bus.DP_RAM_regW); end
    n_vec++; if (bus.DP_RAM_addr_in !== 15'd0) begin n_err++; $display("FAIL mid_rst_addr: got %h exp 0", bus.DP_RAM_addr_in); end
    n_vec++; if (bus.DP_RAM_data_in !== 12'd0) begin n_err++; $display("FAIL mid_rst_data: got %h exp 0", bus.DP_RAM_data_in); end
    rst = 1'b0;
    for (int i = 6; i < line_q.size(); i++) pclk_cycle(line_q[i], 1'b1, 1'b0);
    pclk_cycle(8'h00, 1'b0, 1'b0);
    for (int l = 0; l < 2; l++) begin
      make_line(8);
      foreach (line_q[i]) pclk_cycle(line_q[i], 1'b1, 1'b0);
      pclk_cycle(8'h00, 1'b0, 1'b0);
    end
    settle();
    n_vec++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL mid_count: got %0d exp %0d", obs_q.size(), exp_q.size()); end
    n0 = obs_q.size();
    frame_start(1'b0);
    make_line(4);
    send_line();
    settle();
    n_vec++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL mid_resume_count: got %0d exp %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_vec++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL mid_wr[%0d]: got %h exp %h", i, obs_q[i], exp_q[i]); end
    end
    if (obs_q.size() > n0) begin
      n_vec++; if (obs_q[n0][26:12] !== 15'd0) begin n_err++; $display("FAIL mid_first_addr: got %0d exp 0", obs_q[n0][26:12]); end
    end
    frame_end();
    settle();
  endtask

  initial begin
    bus.CAM_PCLK    = 1'b0;
    bus.CAM_VSYNC   = 1'b1;
    bus.CAM_HREF    = 1'b0;
    bus.CAM_px_data = 8'h00;
    test_reset();
    test_single_line();
    test_full_frame();
    test_overflow();
    test_odd_line();
    test_latency();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
